// File: rtl/dmem_arb.sv
// Two-port (core + debug) arbiter in front of a single-ported data RAM.
// One request in flight; sub-word stores are done as read-modify-write.
module dmem_arb #(
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 4096,
  parameter int MEM_DEPTH_W = $clog2(MEM_DEPTH),
  localparam int BA_W       = MEM_DEPTH_W + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_c_valid,
  output logic                   o_c_ready,
  input  logic                   i_c_we,
  input  logic [1:0]             i_c_size,
  input  logic                   i_c_uns,
  input  logic [BA_W-1:0]        i_c_addr,
  input  logic [DATA_W-1:0]      i_c_wdata,
  output logic                   o_c_rvalid,
  output logic                   o_c_err,
  input  logic                   i_d_valid,
  output logic                   o_d_ready,
  input  logic                   i_d_we,
  input  logic [MEM_DEPTH_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0]      i_d_wdata,
  output logic                   o_d_rvalid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_ram_wena,
  output logic [MEM_DEPTH_W-1:0] o_ram_waddr,
  output logic [DATA_W-1:0]      o_ram_wdata,
  output logic [MEM_DEPTH_W-1:0] o_ram_raddr,
  input  logic [DATA_W-1:0]      i_ram_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RESP   = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_RMW_RD = 3'd4;
  localparam logic [2:0] S_RMW_WR = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [DATA_W-1:0] BYTE_M = {{(DATA_W-8){1'b0}}, 8'hff};
  localparam logic [DATA_W-1:0] HALF_M = {{(DATA_W-16){1'b0}}, 16'hffff};

  typedef struct packed {
    logic                   dbg;
    logic                   we;
    logic [1:0]             size;
    logic                   uns;
    logic [1:0]             boff;
    logic [MEM_DEPTH_W-1:0] waddr;
    logic [DATA_W-1:0]      wdata;
  } req_t;

  logic [2:0] state, state_nxt;
  logic       rr;   // 0: core has priority on contention, 1: debug
  req_t       req_q, req_in;
  logic       c_gnt, d_gnt, c_illegal;

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst && state == S_IDLE) begin
      if (i_c_valid && i_d_valid) begin
        c_gnt = !rr;
        d_gnt = rr;
      end else begin
        c_gnt = i_c_valid;
        d_gnt = i_d_valid;
      end
    end
  end

  assign o_c_ready = c_gnt;
  assign o_d_ready = d_gnt;

  assign c_illegal = (i_c_size == 2'b11) ||
                     (i_c_size == SZ_H && i_c_addr[0]) ||
                     (i_c_size == SZ_W && (|i_c_addr[1:0]));

  always_comb begin
    if (d_gnt) begin
      req_in.dbg   = 1'b1;
      req_in.we    = i_d_we;
      req_in.size  = SZ_W;
      req_in.uns   = 1'b0;
      req_in.boff  = 2'b00;
      req_in.waddr = i_d_addr;
      req_in.wdata = i_d_wdata;
    end else begin
      req_in.dbg   = 1'b0;
      req_in.we    = i_c_we;
      req_in.size  = i_c_size;
      req_in.uns   = i_c_uns;
      req_in.boff  = i_c_addr[1:0];
      req_in.waddr = i_c_addr[BA_W-1:2];
      req_in.wdata = i_c_wdata;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (c_gnt && c_illegal)  state_nxt = S_ERR;
        else if (c_gnt || d_gnt) begin
          if (!req_in.we)                state_nxt = S_RD;
          else if (req_in.size == SZ_W)  state_nxt = S_WR;
          else                           state_nxt = S_RMW_RD;
        end
      end
      S_RD:     state_nxt = S_RESP;
      S_RMW_RD: state_nxt = S_RMW_WR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rr    <= 1'b0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (c_gnt || d_gnt) begin
        req_q <= req_in;
        rr    <= c_gnt;
      end
    end
  end

  // Lane extraction and merge both work off the registered RAM output.
  logic [4:0]        sh;
  logic [DATA_W-1:0] shifted, load_data, lane_mask, merged;

  assign sh      = {req_q.boff, 3'b000};
  assign shifted = i_ram_rdata >> sh;

  always_comb begin
    case (req_q.size)
      SZ_B:    load_data = req_q.uns ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                     : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = req_q.uns ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                     : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      default: load_data = i_ram_rdata;
    endcase
  end

  assign lane_mask = ((req_q.size == SZ_B) ? BYTE_M : HALF_M) << sh;
  assign merged    = (i_ram_rdata & ~lane_mask) | ((req_q.wdata << sh) & lane_mask);

  always_comb begin
    o_c_rvalid  = 1'b0;
    o_d_rvalid  = 1'b0;
    o_c_err     = 1'b0;
    o_rdata     = '0;
    o_ram_wena  = 1'b0;
    o_ram_waddr = '0;
    o_ram_wdata = '0;
    o_ram_raddr = '0;
    if (!rst) begin
      case (state)
        S_RD, S_RMW_RD: o_ram_raddr = req_q.waddr;
        S_RESP: begin
          o_c_rvalid = !req_q.dbg;
          o_d_rvalid = req_q.dbg;
          o_rdata    = load_data;
        end
        S_WR, S_RMW_WR: begin
          o_ram_wena  = 1'b1;
          o_ram_waddr = req_q.waddr;
          o_ram_wdata = (state == S_WR) ? req_q.wdata : merged;
          o_c_rvalid  = !req_q.dbg;
          o_d_rvalid  = req_q.dbg;
        end
        S_ERR: begin
          o_c_rvalid = 1'b1;
          o_c_err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed self-checking bench for dmem_arb with a behavioural 1-cycle RAM.
module tb_dmem_arb;
  logic        clk, rst;
  logic        c_valid, c_ready, c_we, c_uns, c_rvalid, c_err;
  logic [1:0]  c_size;
  logic [13:0] c_addr;
  logic [31:0] c_wdata;
  logic        d_valid, d_ready, d_we, d_rvalid;
  logic [11:0] d_addr;
  logic [31:0] d_wdata, rdata;
  logic        ram_wena;
  logic [11:0] ram_waddr, ram_raddr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] mem [0:4095];
  int n_chk, n_fail;

  dmem_arb dut (
    .clk(clk), .rst(rst),
    .i_c_valid(c_valid), .o_c_ready(c_ready), .i_c_we(c_we), .i_c_size(c_size),
    .i_c_uns(c_uns), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_rvalid(c_rvalid), .o_c_err(c_err),
    .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_we(d_we), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_rvalid(d_rvalid), .o_rdata(rdata),
    .o_ram_wena(ram_wena), .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata),
    .o_ram_raddr(ram_raddr), .i_ram_rdata(ram_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_wena) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  // Drive a core request from a negedge; returns 1ns after the handshake edge.
  task automatic core_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [13:0] addr, input logic [31:0] wdata);
    bit got = 0;
    c_valid = 1; c_we = we; c_size = size; c_uns = uns; c_addr = addr; c_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (c_ready) begin got = 1; break; end
      @(negedge clk);
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL core_handshake: no ready for addr %h", addr); end
    else begin @(posedge clk); #1; end
    c_valid = 0;
  endtask

  task automatic dbg_req(input logic we, input logic [11:0] addr, input logic [31:0] wdata);
    bit got = 0;
    d_valid = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (d_ready) begin got = 1; break; end
      @(negedge clk);
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL dbg_handshake: no ready for addr %h", addr); end
    else begin @(posedge clk); #1; end
    d_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1; c_valid = 1; d_valid = 1;
    @(negedge clk); #1;
    n_chk++;
    if ({c_ready, d_ready, c_rvalid, c_err, d_rvalid, ram_wena} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {c_ready, d_ready, c_rvalid, c_err, d_rvalid, ram_wena});
    end
    n_chk++;
    if ({rdata, ram_wdata, ram_waddr, ram_raddr} !== '0) begin
      n_fail++; $display("FAIL reset_data: rdata %h wdata %h waddr %h raddr %h want 0", rdata, ram_wdata, ram_waddr, ram_raddr);
    end
    c_valid = 0; d_valid = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_word_store_load;
    core_req(1, 2'b10, 0, 14'h10, 32'hDEADBEEF);
    @(negedge clk);
    n_chk++;
    if ({ram_wena, ram_waddr, ram_wdata, c_rvalid, c_err} !== {1'b1, 12'd4, 32'hDEADBEEF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sw_write: wena %b waddr %h wdata %h rv %b err %b want 1 004 deadbeef 1 0", ram_wena, ram_waddr, ram_wdata, c_rvalid, c_err);
    end
    @(negedge clk);
    n_chk++;
    if ({ram_wena, c_rvalid} !== 2'b00) begin n_fail++; $display("FAIL sw_idle: wena/rv %b want 00", {ram_wena, c_rvalid}); end
    core_req(0, 2'b10, 0, 14'h10, 32'h0);
    @(negedge clk);
    n_chk++;
    if ({ram_raddr, c_rvalid} !== {12'd4, 1'b0}) begin n_fail++; $display("FAIL lw_rd: raddr %h rv %b want 004 0", ram_raddr, c_rvalid); end
    @(negedge clk);
    n_chk++;
    if ({c_rvalid, rdata} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL lw_resp: rv %b rdata %h want 1 deadbeef", c_rvalid, rdata); end
  endtask

  task automatic test_subword;
    logic [13:0] a [4] = '{14'h13, 14'h13, 14'h12, 14'h10};
    logic        u [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  s [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic [31:0] e [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h00007FEF};
    core_req(1, 2'b00, 0, 14'h11, 32'h0000007F);
    @(negedge clk);
    n_chk++;
    if ({ram_raddr, ram_wena, c_rvalid} !== {12'd4, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sb_rmw_rd: raddr %h wena %b rv %b want 004 0 0", ram_raddr, ram_wena, c_rvalid);
    end
    @(negedge clk);
    n_chk++;
    if ({ram_wena, ram_waddr, ram_wdata, c_rvalid, rdata} !== {1'b1, 12'd4, 32'hDEAD7FEF, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL sb_rmw_wr: wena %b waddr %h wdata %h rv %b rdata %h want 1 004 dead7fef 1 0", ram_wena, ram_waddr, ram_wdata, c_rvalid, rdata);
    end
    for (int i = 0; i < 4; i++) begin
      core_req(0, s[i], u[i], a[i], 32'h0);
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({c_rvalid, rdata} !== {1'b1, e[i]}) begin
        n_fail++; $display("FAIL subword_load[%0d]: rv %b rdata %h want 1 %h", i, c_rvalid, rdata, e[i]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [13:0] a [3] = '{14'h21, 14'h02, 14'h10};
    logic [1:0]  s [3] = '{2'b01, 2'b10, 2'b11};
    logic        w [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      core_req(w[i], s[i], 0, a[i], 32'hFFFFFFFF);
      @(negedge clk);
      n_chk++;
      if ({c_rvalid, c_err, rdata, ram_wena} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        n_fail++; $display("FAIL illegal_err[%0d]: rv %b err %b rdata %h wena %b want 1 1 0 0", i, c_rvalid, c_err, rdata, ram_wena);
      end
      @(negedge clk);
      n_chk++;
      if ({c_rvalid, c_err, ram_wena} !== 3'b000) begin
        n_fail++; $display("FAIL illegal_after[%0d]: rv/err/wena %b want 000", i, {c_rvalid, c_err, ram_wena});
      end
    end
  endtask

  task automatic test_debug;
    dbg_req(1, 12'd6, 32'h12345678);
    @(negedge clk);
    n_chk++;
    if ({ram_wena, ram_waddr, ram_wdata, d_rvalid, c_rvalid} !== {1'b1, 12'd6, 32'h12345678, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL dbg_write: wena %b waddr %h wdata %h drv %b crv %b want 1 006 12345678 1 0", ram_wena, ram_waddr, ram_wdata, d_rvalid, c_rvalid);
    end
    @(negedge clk);
    dbg_req(0, 12'd4, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({d_rvalid, c_rvalid, rdata} !== {1'b1, 1'b0, 32'hDEAD7FEF}) begin
      n_fail++; $display("FAIL dbg_read: drv %b crv %b rdata %h want 1 0 dead7fef", d_rvalid, c_rvalid, rdata);
    end
    core_req(0, 2'b10, 0, 14'h18, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({c_rvalid, rdata} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL dbg_then_core: rv %b rdata %h want 1 12345678", c_rvalid, rdata); end
  endtask

  task automatic test_round_robin;
    int gseq[$];
    int c_rv = 0, d_rv = 0, both = 0, bad_data = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    c_valid = 1; c_we = 0; c_size = 2'b10; c_uns = 0; c_addr = 14'h10;
    d_valid = 1; d_we = 0; d_addr = 12'd6;
    for (int i = 0; i < 16; i++) begin
      if (i == 12) begin c_valid = 0; d_valid = 0; end
      #1;
      if (c_ready && d_ready) both++;
      if (c_ready) gseq.push_back(0);
      if (d_ready) gseq.push_back(1);
      if (c_rvalid) begin c_rv++; if (rdata !== 32'hDEAD7FEF) bad_data++; end
      if (d_rvalid) begin d_rv++; if (rdata !== 32'h12345678) bad_data++; end
      @(negedge clk);
    end
    n_chk++;
    if (gseq.size() != 4 || both != 0) begin n_fail++; $display("FAIL rr_grants: got %0d grants (%0d double) want 4 (0)", gseq.size(), both); end
    for (int i = 0; i < gseq.size() && i < 4; i++) begin
      n_chk++;
      if (gseq[i] != i % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got port %0d want %0d", i, gseq[i], i % 2); end
    end
    n_chk++;
    if (c_rv != 2 || d_rv != 2 || bad_data != 0) begin
      n_fail++; $display("FAIL rr_responses: core %0d dbg %0d bad %0d want 2 2 0", c_rv, d_rv, bad_data);
    end
  endtask

  task automatic test_reset_rmw;
    core_req(1, 2'b00, 0, 14'h11, 32'h00000055);
    rst = 1;
    @(negedge clk);
    n_chk++;
    if ({ram_wena, c_rvalid, ram_raddr} !== {1'b0, 1'b0, 12'd0}) begin
      n_fail++; $display("FAIL rst_rmw_during: wena %b rv %b raddr %h want 0 0 000", ram_wena, c_rvalid, ram_raddr);
    end
    @(negedge clk);
    rst = 0;
    #1;
    n_chk++;
    if ({ram_wena, c_rvalid, c_ready} !== 3'b000) begin
      n_fail++; $display("FAIL rst_rmw_after: wena/rv/ready %b want 000", {ram_wena, c_rvalid, c_ready});
    end
    core_req(0, 2'b10, 0, 14'h10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({c_rvalid, rdata} !== {1'b1, 32'hDEAD7FEF}) begin n_fail++; $display("FAIL rst_rmw_mem: rv %b rdata %h want 1 dead7fef", c_rvalid, rdata); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    n_chk = 0; n_fail = 0;
    rst = 1; c_valid = 0; c_we = 0; c_size = 0; c_uns = 0; c_addr = 0; c_wdata = 0;
    d_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    @(negedge clk);
    test_reset;
    test_word_store_load;
    test_subword;
    test_illegal;
    test_debug;
    test_round_robin;
    test_reset_rmw;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, which sets the RAM word width and the requester data width.
REQ-002 SHALL have parameter MEM_DEPTH, default 4096, which sets the number of RAM words.
REQ-003 SHALL have parameter MEM_DEPTH_W, default clogb2(MEM_DEPTH) = 12, which sets the RAM word-address width; byte address width BA_W = MEM_DEPTH_W+2.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_c_valid  input  1  core request valid.
REQ-008 o_c_ready  output  1  core request accepted this cycle.
REQ-009 i_c_we  input  1  core store (1) / load (0).
REQ-010 i_c_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 i_c_uns  input  1  zero-extend loads (LBU/LHU).
REQ-012 i_c_addr  input  BA_W  core byte address.
REQ-013 i_c_wdata  input  DATA_W  core store data, LSB-aligned.
REQ-014 o_c_rvalid  output  1  core response pulse (load data or store ack).
REQ-015 o_c_err  output  1  core misaligned/illegal flag, valid with o_c_rvalid.
REQ-016 i_d_valid / o_d_ready / i_d_we  input/output/input  1 each  debug-port word request, accept, store flag.
REQ-017 i_d_addr  input  MEM_DEPTH_W  debug word address.
REQ-018 i_d_wdata  input  DATA_W  debug store word.
REQ-019 o_d_rvalid  output  1  debug response pulse.
REQ-020 o_rdata  output  DATA_W  shared response data, valid with either rvalid; 0 for stores/errors.
REQ-021 o_ram_wena / o_ram_waddr / o_ram_wdata  output  1 / MEM_DEPTH_W / DATA_W  dmem write port.
REQ-022 o_ram_raddr / i_ram_rdata  output / input  MEM_DEPTH_W / DATA_W  dmem read port; data registered, valid the cycle after the address is sampled.

Function
REQ-023 States: IDLE, RD, RESP, WR, RMW_RD, RMW_WR, ERR; one request in flight at a time.
REQ-024 o_c_ready / o_d_ready SHALL be asserted only in IDLE, for at most one port: the sole valid port, or on contention the port selected by round-robin pointer rr.
REQ-025 rr SHALL point at the non-granted port after every handshake; it resets to core.
REQ-026 On handshake at edge T: latch port, we, size, uns, addr, wdata; next state is ERR if illegal, WR for word store, RMW_RD for sub-word store, else RD.
REQ-027 Core illegal: size=11, half with addr[0]=1, word with addr[1:0]!=0; ERR cycle (T+1) pulses o_c_rvalid, o_c_err=1, o_rdata=0, no RAM write; then IDLE.
REQ-028 Load: RD at T+1 drives o_ram_raddr=addr word; RESP at T+2 pulses rvalid, o_rdata = lane addr[1:0] of i_ram_rdata, sign- or zero-extended per size/uns; then IDLE.
REQ-029 Word store: WR at T+1 drives o_ram_wena=1 and the latched address/data, pulses rvalid; then IDLE.
REQ-030 Sub-word store: RMW_RD at T+1 reads word; RMW_WR at T+2 writes the word with only the addressed byte/half lane replaced by wdata LSBs, pulses rvalid; then IDLE.
REQ-031 o_ram_wena SHALL be 0 in every other state; debug port always word-sized, never errors; o_c_err=0 except in ERR.
REQ-032 Peak throughput: one request per 2 cycles (word store) or per 3 cycles (load, RMW).

Reset
REQ-033 While rst=1: state IDLE, rr=core, all outputs 0 including ready and o_ram_wena; any in-flight request is dropped with no write and no response.

Verification
REQ-034 Core SW 0xDEADBEEF @0x10, then LW @0x10 -> o_ram_wena pulse at word 4; load rvalid 2 cycles after handshake, o_rdata=0xDEADBEEF.
REQ-035 SB 0x7F @0x11 over 0xDEADBEEF, then LB/LBU @0x13 -> written word 0xDEAD7FEF; LB gives 0xFFFFFFDE, LBU gives 0x000000DE.
REQ-036 Core LH @0x21 -> o_c_rvalid and o_c_err =1 at T+1, no RAM write, o_rdata=0.
REQ-037 Both ports valid continuously after reset -> grants alternate core, debug, core...; no response is lost or duplicated.
REQ-038 rst asserted during RMW_RD -> next cycle IDLE, o_ram_wena stays 0, no rvalid; memory word unchanged.
